an_encoder_28bits: RTL and testbench
====================================

// Module: an_encoder_28bits
// PURPOSE
//  Product (AN) code encoder, the transmit side of the SEC AN path. Multiplies a
//  28-bit unsigned operand by check constant A=83 to form the 35-bit codeword A*N.
//  Sequential shift-add, one multiplier bit per cycle. Valid/ready on both sides.
//  The 28-bit SEC decoder consumes the codeword: residue mod 83 gives r, r gives the AWE.
// PARAMETERS
//  DATA_W  28  operand width N
//  A       83  check constant; order of 2 mod 83 is 82, so +/-2^0..2^40 are unique
//  A_W     7   bit width of A (1010011b); also the number of BUSY cycles
//  CW_W    35  codeword width = DATA_W+A_W; must stay <= 41 (decoder AWE range)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       operand valid
//  in_ready   out  1       encoder can accept an operand (high only in IDLE)
//  in_data    in   DATA_W  operand N, unsigned
//  out_valid  out  1       codeword valid; held until accepted
//  out_ready  in   1       downstream accepts the codeword
//  out_cw     out  CW_W    codeword A*N, unsigned
//  chk_err    out  1       self-check: (out_cw mod A) != 0; qualified by out_valid
// BEHAVIOUR
//  Reset (sync, any state, including mid-BUSY): state=IDLE, acc=0, cnt=0, out_cw=0,
//   out_valid=0, chk_err=0, in_ready=1 from the first cycle after reset.
//   An in-flight operand is discarded and no codeword is emitted.
//  FSM: IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid && in_ready: latch N (zero-extend to CW_W),
//    acc=0, cnt=0, go to BUSY.
//   BUSY: in_ready=0. Each edge: if A[cnt], acc += N<<cnt. Then cnt++.
//    After the edge that processes cnt=A_W-1: out_cw=final acc, chk_err=residue!=0,
//    out_valid=1, go to DONE.
//   DONE: out_valid=1. out_cw and chk_err are stable while out_ready=0.
//    On out_ready: out_valid=0, go to IDLE.
//  Latency: handshake at edge T0; out_valid is high after edge T0+A_W (7 cycles).
//   Minimum initiation interval is A_W+2 = 9 cycles.
//  Width: CW_W accumulator. A*(2^28-1) < 2^35, so there is no overflow and no
//   truncation. N=0 gives cw=0.
//  in_valid while BUSY/DONE: ignored; the operand must be held until in_ready.
//  out_ready while not out_valid: no effect.
//  rst together with a handshake: rst wins.
//  cnt: 3 bits, never wraps past A_W-1.
// STRUCTURE
//  Shared package an_pkg: AN_A=83, AN_A_W=7, AN_DATA_W=28, AN_CW_W=35, plus the FSM
//   state typedef {IDLE,BUSY,DONE}. The decoder side uses the same package.
//  One sub-module, an_mod_residue: combinational CW_W-bit mod-A fold producing a
//   7-bit residue. It drives chk_err here and is reused by the decoder for r.
// TESTING
//  1 N=1 -> out_cw=83 (0x53), out_valid exactly 7 cycles after handshake, chk_err=0.
//  2 N=0x0FFFFFFF -> out_cw=0x52FFFFFAD (22280142765), chk_err=0; N=0 -> out_cw=0.
//  3 Backpressure: out_ready=0 for 5 cycles after DONE -> out_cw/out_valid held,
//    in_ready=0, a new in_valid is ignored; out_ready=1 -> IDLE next cycle.
//  4 rst pulsed on the 3rd BUSY cycle -> all outputs 0, in_ready=1 next cycle,
//    no out_valid; the next operand N=5 -> out_cw=415.
//  5 Round trip: N=12345 -> cw=1024635. Flip bit 10 (+1024) -> residue 28 ->
//    decoder AWE=+1024 -> cw-AWE == 1024635, /83 == 12345.
//  6 Back-to-back: in_valid held with N=2,3 -> out_cw=166 then 249, in order,
//    9-cycle interval; random N sweep vs a 35-bit reference model.

Source files
------------

// File: rtl/an_pkg.sv
// Shared definitions for the AN (product code) encoder and decoder pair.
// A=83 is chosen so that +/-2^0..2^40 leave distinct residues.
package an_pkg;

    localparam int AN_A      = 83;
    localparam int AN_A_W    = 7;
    localparam int AN_DATA_W = 28;
    localparam int AN_CW_W   = AN_DATA_W + AN_A_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } an_state_t;

    // Weight of bit position i modulo A; evaluated on constant loop indices only.
    function automatic logic [AN_A_W-1:0] pow2_mod(input int i);
        int r;
        r = 1;
        for (int k = 0; k < i; k++) begin
            r = (r * 2) % AN_A;
        end
        return AN_A_W'(r);
    endfunction

endpackage

// File: rtl/an_mod_residue.sv
// Combinational residue of a codeword modulo A.
// Shared by the encoder self-check and the decoder syndrome path.
module an_mod_residue
    import an_pkg::*;
(
    input  logic [AN_CW_W-1:0] cw,
    output logic [AN_A_W-1:0]  residue
);

    // 35 weights below 83 sum to at most 2870, well inside 12 bits and below 64*A.
    localparam int SUM_W = 12;

    logic [SUM_W-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < AN_CW_W; i++) begin
            if (cw[i]) begin
                sum = sum + SUM_W'(pow2_mod(i));
            end
        end
        // Restoring reduction by A*32 .. A*1 leaves a value below A.
        for (int k = 5; k >= 0; k--) begin
            if (sum >= (SUM_W'(AN_A) << k)) begin
                sum = sum - (SUM_W'(AN_A) << k);
            end
        end
        residue = sum[AN_A_W-1:0];
    end

endmodule

// File: rtl/an_encoder_28bits.sv
// AN code encoder: out_cw = 83 * in_data via shift-add, one multiplier bit per cycle.
// Valid/ready on both sides; chk_err flags a codeword that is not a multiple of A.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// BUSY  | accumulating N<<cnt for each set bit of A, cnt = 0..A_W-1
// DONE  | codeword presented, held until out_ready
module an_encoder_28bits
    import an_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AN_DATA_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AN_CW_W-1:0]   out_cw,
    output logic                 chk_err
);

    // A padded to 8 bits so every 3-bit cnt value is a legal index.
    localparam logic [7:0] A_VEC = 8'(AN_A);
    localparam logic [2:0] CNT_LAST = 3'(AN_A_W - 1);

    an_state_t            state, state_nxt;
    logic [AN_DATA_W-1:0] n_q, n_nxt;
    logic [AN_CW_W-1:0]   acc, acc_nxt;
    logic [AN_CW_W-1:0]   cw_q, cw_nxt;
    logic [AN_CW_W-1:0]   addend;
    logic [2:0]           cnt, cnt_nxt;
    logic [AN_A_W-1:0]    residue;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            n_q   <= '0;
            acc   <= '0;
            cw_q  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            n_q   <= n_nxt;
            acc   <= acc_nxt;
            cw_q  <= cw_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        n_nxt     = n_q;
        acc_nxt   = acc;
        cw_nxt    = cw_q;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        addend    = A_VEC[cnt] ? (AN_CW_W'(n_q) << cnt) : '0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    n_nxt     = in_data;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                acc_nxt = acc + addend;
                if (cnt == CNT_LAST) begin
                    cw_nxt    = acc + addend;
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    an_mod_residue u_residue (
        .cw      (cw_q),
        .residue (residue)
    );

    assign out_cw  = cw_q;
    assign chk_err = out_valid && (residue != '0);

endmodule

// File: tb/tb_an_encoder_28bits.sv
// Scoreboard bench for an_encoder_28bits: driver pushes expected codewords,
// a negedge monitor pops and compares them when the encoder presents a result.
module tb_an_encoder_28bits;
    import an_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [AN_DATA_W-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [AN_CW_W-1:0]   out_cw;
    logic                 chk_err;

    logic [AN_CW_W-1:0]   probe_cw;
    logic [AN_A_W-1:0]    probe_res;

    typedef struct {
        logic [AN_CW_W-1:0] cw;
        int                 t0;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   prev_v = 1'b0;

    an_encoder_28bits dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cw    (out_cw),
        .chk_err   (chk_err)
    );

    an_mod_residue u_probe (
        .cw      (probe_cw),
        .residue (probe_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: latency on each rising out_valid, data on each accepted codeword.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_v) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    chk("latency", 64'(cyc - q[0].t0), 64'd7);
                end
            end
            if (out_valid && out_ready && q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("out_cw", 64'(out_cw), 64'(e.cw));
                chk("chk_err", 64'(chk_err), 64'd0);
            end
        end
        prev_v = out_valid;
    end

    task automatic send(input logic [AN_DATA_W-1:0] n, input logic [AN_CW_W-1:0] exp,
                        input bit push, output int t0);
        bit done;
        done = 1'b0;
        t0 = -1;
        in_valid = 1'b1;
        in_data  = n;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                t0 = cyc + 1;
                if (push) q.push_back('{cw: exp, t0: t0});
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            in_valid = 1'b0;
            chk("handshake_timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 200 && !empty; i++) begin
            @(negedge clk);
            if (q.size() == 0) empty = 1'b1;
        end
        if (!empty) chk("drain_timeout", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t_a, t_b, t_x;
        logic [63:0] awe, corrected;
        logic [AN_DATA_W-1:0] rn;
        bit found;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        probe_cw  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_cw", 64'(out_cw), 64'd0);
        chk("rst_chk_err", 64'(chk_err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic values, all-ones operand and zero.
        send(28'd1, 35'd83, 1'b1, t_x);
        send(28'h0FFFFFFF, 35'h52FFFFFAD, 1'b1, t_x);
        send(28'd0, 35'd0, 1'b1, t_x);
        drain();

        // Backpressure: hold result for 5 cycles while a new operand is offered.
        out_ready = 1'b0;
        send(28'd77, 35'd6391, 1'b1, t_x);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            if (!seen) chk("bp_valid_timeout", 64'd0, 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 28'd999;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_cw", 64'(out_cw), 64'd6391);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Reset during the third BUSY cycle discards the operand.
        send(28'd9, 35'd0, 1'b0, t_x);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_cw", 64'(out_cw), 64'd0);
        chk("midrst_chk_err", 64'(chk_err), 64'd0);
        repeat (12) @(posedge clk);
        #1;
        send(28'd5, 35'd415, 1'b1, t_x);
        drain();

        // Round trip through the shared residue block and a bench-side AWE lookup.
        send(28'd12345, 35'd1024635, 1'b1, t_x);
        drain();
        probe_cw = 35'd1024635;
        #1;
        chk("res_clean", 64'(probe_res), 64'd0);
        probe_cw = 35'd1024635 ^ 35'd1024;
        #1;
        chk("res_flip10", 64'(probe_res), 64'd28);
        found = 1'b0;
        awe = 64'd0;
        for (int k = 0; k <= 40; k++) begin
            if (!found && ((64'd1 << k) % 64'd83) == 64'(probe_res)) begin
                awe = 64'd1 << k;
                found = 1'b1;
            end
        end
        corrected = 64'(probe_cw) - awe;
        chk("rt_corrected", corrected, 64'd1024635);
        chk("rt_decoded", corrected / 64'd83, 64'd12345);

        // Back-to-back operands: 9-cycle initiation interval.
        send(28'd2, 35'd166, 1'b1, t_a);
        send(28'd3, 35'd249, 1'b1, t_b);
        chk("b2b_interval", 64'(t_b - t_a), 64'd9);
        drain();

        // Random sweep against a 64-bit multiply.
        for (int i = 0; i < 8; i++) begin
            rn = AN_DATA_W'($urandom);
            send(rn, AN_CW_W'(64'(rn) * 64'd83), 1'b1, t_x);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
